// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier arbiter and its response FIFO.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mult_pkg;

  localparam int MULT_W   = 32;
  localparam int PROD_W   = 64;
  // Widest requester ID supported (NREQ up to 8); narrower IDs are zero-extended.
  localparam int ID_MAX_W = 3;

  // One multiplier issue: operands plus their sign modes (1 = signed).
  typedef struct packed {
    logic              ns_a;
    logic              ns_b;
    logic [MULT_W-1:0] a;
    logic [MULT_W-1:0] b;
  } mult_op_t;

  // One response entry: requester index and its product.
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   product;
  } mult_rsp_t;

  // Next round-robin start position after index idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mult_rsp_fifo.sv
// Sync FIFO whose head sits in an output register (no write-to-head bypass).
// Latency: a push becomes visible on the head two edges later when empty.
// Backpressure: pop is the consumer accept; caller must not push when full.
module mult_rsp_fifo #(
  parameter int W     = 67,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          head_vld;
  logic          load;

  // Refill the head register whenever it is free or being consumed this cycle.
  assign load  = (mem_cnt != '0) && (!head_vld || pop);
  assign count = mem_cnt + (AW+1)'(head_vld);
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = !head_vld;

  // Storage array; contents need no reset since occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Write/read pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, load})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // Registered head entry presented to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld <= 1'b0;
      rdata    <= '0;
    end else if (load) begin
      head_vld <= 1'b1;
      rdata    <= mem[rd_ptr];
    end else if (pop) begin
      head_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters.
// Latency: accept edge t -> response valid after edge t+MULT_LAT+2.
// Backpressure: credits (in flight + queued) cap grants at FIFO_DEPTH.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int MULT_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [NREQ-1:0]      i_req_vld,
  output logic [NREQ-1:0]      o_req_rdy,
  input  logic [NREQ-1:0]      i_req_a_ns,
  input  logic [NREQ-1:0]      i_req_b_ns,
  input  logic [NREQ*32-1:0]   i_req_a,
  input  logic [NREQ*32-1:0]   i_req_b,
  output logic                 o_mult_vld,
  output logic                 o_multa_ns,
  output logic                 o_multb_ns,
  output logic [31:0]          o_multa,
  output logic [31:0]          o_multb,
  input  logic [63:0]          i_product,
  output logic                 o_rsp_vld,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [63:0]          o_rsp_product,
  input  logic                 i_rsp_rdy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [IDW-1:0]       rr_ptr;
  logic [CW-1:0]        credit;
  logic                 credit_ok;
  logic [NREQ-1:0]      grant_vec;
  logic                 grant_any;
  logic [IDW-1:0]       grant_idx;
  mult_op_t             sel_op;
  mult_op_t             issue_op;
  logic                 issue_vld;
  logic [IDW-1:0]       issue_id;
  logic [MULT_LAT-1:0]  tag_vld;
  logic [IDW-1:0]       tag_id [MULT_LAT];
  mult_rsp_t            rsp_in;
  mult_rsp_t            rsp_head;
  logic                 rsp_push;
  logic                 rsp_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  // Every granted request owns a FIFO slot until its response is popped.
  assign credit_ok = (credit < CW'(FIFO_DEPTH));
  assign o_req_rdy = grant_vec;

  // Round-robin search from rr_ptr; first valid requester wins if a slot is free.
  always_comb begin
    int k;
    k         = 0;
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      if (credit_ok && !grant_any && i_req_vld[k]) begin
        grant_any    = 1'b1;
        grant_idx    = IDW'(k);
        grant_vec[k] = 1'b1;
      end
    end
  end

  // Steer the winner's operands and sign modes toward the issue register.
  always_comb begin
    int base;
    base        = int'(grant_idx) * MULT_W;
    sel_op      = '0;
    sel_op.ns_a = i_req_a_ns[grant_idx];
    sel_op.ns_b = i_req_b_ns[grant_idx];
    sel_op.a    = i_req_a[base +: MULT_W];
    sel_op.b    = i_req_b[base +: MULT_W];
  end

  // Pointer moves just past the winner; idle cycles leave it where it is.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= IDW'(rr_next(int'(grant_idx), NREQ));
    end
  end

  // Credit count: +1 per grant, -1 per response pop, unchanged when both occur.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      credit <= '0;
    end else begin
      case ({grant_any, rsp_pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // Issue register: operands only load on a grant so idle cycles do not toggle the datapath.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      issue_vld <= 1'b0;
      issue_op  <= '0;
      issue_id  <= '0;
    end else begin
      issue_vld <= grant_any;
      if (grant_any) begin
        issue_op <= sel_op;
        issue_id <= grant_idx;
      end
    end
  end

  assign o_mult_vld = issue_vld;
  assign o_multa_ns = issue_op.ns_a;
  assign o_multb_ns = issue_op.ns_b;
  assign o_multa    = issue_op.a;
  assign o_multb    = issue_op.b;

  // Tag pipeline mirrors the multiplier depth so the tail lines up with i_product.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tag_vld <= '0;
      for (int s = 0; s < MULT_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld[0] <= issue_vld;
      tag_id[0]  <= issue_id;
      for (int s = 1; s < MULT_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign rsp_push = tag_vld[MULT_LAT-1];
  assign rsp_pop  = o_rsp_vld && i_rsp_rdy;

  // Pair the product arriving now with the requester that issued it.
  always_comb begin
    rsp_in              = '0;
    rsp_in.id[IDW-1:0]  = tag_id[MULT_LAT-1];
    rsp_in.product      = i_product;
  end

  mult_rsp_fifo #(
    .W     ($bits(mult_rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (rsp_push),
    .wdata (rsp_in),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_rsp_vld     = !fifo_empty;
  assign o_rsp_id      = rsp_head.id[IDW-1:0];
  assign o_rsp_product = rsp_head.product;

  // At most one requester is accepted per cycle.
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn)
    $onehot0(o_req_rdy));

  // Credits bound the FIFO, so a push never meets a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(fifo_full && rsp_push && !rsp_pop));

  // Queued entries are always a subset of outstanding credits.
  a_credit_cover: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (credit >= fifo_count) && (credit <= CW'(FIFO_DEPTH)));

  // Unused high ID bits stay zero through the FIFO.
  a_id_ext: assert property (@(posedge i_clk) disable iff (!i_rstn)
    rsp_head.id == ID_MAX_W'(o_rsp_id));

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier and a response scoreboard.
// Latency: checks accept-to-response latency of MULT_LAT+2.
// Backpressure: exercises i_rsp_rdy stalls and credit-limited grants.
module tb_mult_arbiter;

  localparam int NREQ       = 4;
  localparam int IDW        = 2;
  localparam int MULT_LAT   = 2;
  localparam int FIFO_DEPTH = 4;

  logic                 i_clk = 1'b0;
  logic                 i_rstn = 1'b0;
  logic [NREQ-1:0]      i_req_vld;
  logic [NREQ-1:0]      o_req_rdy;
  logic [NREQ-1:0]      i_req_a_ns;
  logic [NREQ-1:0]      i_req_b_ns;
  logic [NREQ*32-1:0]   i_req_a;
  logic [NREQ*32-1:0]   i_req_b;
  logic                 o_mult_vld;
  logic                 o_multa_ns;
  logic                 o_multb_ns;
  logic [31:0]          o_multa;
  logic [31:0]          o_multb;
  logic [63:0]          i_product;
  logic                 o_rsp_vld;
  logic [IDW-1:0]       o_rsp_id;
  logic [63:0]          o_rsp_product;
  logic                 i_rsp_rdy = 1'b1;

  mult_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_a_ns(i_req_a_ns), .i_req_b_ns(i_req_b_ns),
    .i_req_a(i_req_a), .i_req_b(i_req_b),
    .o_mult_vld(o_mult_vld), .o_multa_ns(o_multa_ns), .o_multb_ns(o_multb_ns),
    .o_multa(o_multa), .o_multb(o_multb), .i_product(i_product),
    .o_rsp_vld(o_rsp_vld), .o_rsp_id(o_rsp_id), .o_rsp_product(o_rsp_product),
    .i_rsp_rdy(i_rsp_rdy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    product;
  } exp_t;

  op_t  reqq [NREQ][$];
  exp_t exp_q[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t mon_e;

  // Behavioural multiplier: MULT_LAT register stages, sign-extends per ns bit.
  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb);
    logic signed [65:0] ea;
    logic signed [65:0] eb;
    logic signed [65:0] pr;
    ea = {{34{sa & a[31]}}, a};
    eb = {{34{sb & b[31]}}, b};
    pr = ea * eb;
    return pr[63:0];
  endfunction

  logic [63:0] mp1;
  logic [63:0] mp2;
  always @(posedge i_clk) begin
    mp1 <= mul_model(o_multa, o_multb, o_multa_ns, o_multb_ns);
    mp2 <= mp1;
  end
  assign i_product = mp2;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Queue a request for requester k; optionally record its expected response.
  task automatic enq(input int k, input logic [31:0] a, input logic [31:0] b,
                     input logic sa, input logic sb, input logic [63:0] prod, input bit expect_rsp);
    op_t  o;
    exp_t e;
    o.a = a; o.b = b; o.sa = sa; o.sb = sb;
    reqq[k].push_back(o);
    if (expect_rsp) begin
      e.id      = IDW'(k);
      e.product = prod;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_grant(input string name, output logic [NREQ-1:0] vec, output int t_acc);
    int n;
    n   = 0;
    vec = '0;
    do begin
      @(negedge i_clk);
      vec = o_req_rdy & i_req_vld;
      n++;
    end while (vec == '0 && n < 50);
    checks++;
    if (vec == '0) begin
      errors++;
      $display("FAIL %s_grant_timeout: no grant in 50 cycles, required a grant", name);
    end
    t_acc = cyc + 1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic chk_log(input string name, input int n, input int eg[8]);
    chk({name, "_count"}, 64'(grant_log.size()), 64'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++) begin
      chk($sformatf("%s[%0d]", name, i), 64'(grant_log[i]), 64'(eg[i]));
    end
  endtask

  // Requester driver: holds each request stable until its handshake, then loads the next.
  initial begin : driver
    logic [NREQ-1:0] hs;
    i_req_vld  = '0;
    i_req_a_ns = '0;
    i_req_b_ns = '0;
    i_req_a    = '0;
    i_req_b    = '0;
    forever begin
      @(negedge i_clk);
      hs = i_rstn ? (o_req_rdy & i_req_vld) : '0;
      @(posedge i_clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (hs[k] && reqq[k].size() > 0) begin
          void'(reqq[k].pop_front());
          grant_log.push_back(k);
          grant_cyc.push_back(cyc);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (reqq[k].size() > 0) begin
          i_req_vld[k]        = 1'b1;
          i_req_a[32*k +: 32] = reqq[k][0].a;
          i_req_b[32*k +: 32] = reqq[k][0].b;
          i_req_a_ns[k]       = reqq[k][0].sa;
          i_req_b_ns[k]       = reqq[k][0].sb;
        end else begin
          i_req_vld[k] = 1'b0;
        end
      end
    end
  end

  // Response monitor: every accepted response is compared against the scoreboard head.
  always @(negedge i_clk) begin
    if (i_rstn && o_rsp_vld && i_rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d product 0x%0h, required no response",
                 o_rsp_id, o_rsp_product);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 64'(o_rsp_id), 64'(mon_e.id));
        chk("rsp_product", o_rsp_product, mon_e.product);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NREQ-1:0] vec;
    int t_acc;
    int lat;
    int n;
    int seen;
    int eg[8];

    // Reset values
    repeat (3) @(negedge i_clk);
    chk("rst_mult_vld", 64'(o_mult_vld), 64'd0);
    chk("rst_multa", 64'(o_multa), 64'd0);
    chk("rst_multb", 64'(o_multb), 64'd0);
    chk("rst_multa_ns", 64'(o_multa_ns), 64'd0);
    chk("rst_multb_ns", 64'(o_multb_ns), 64'd0);
    chk("rst_rsp_vld", 64'(o_rsp_vld), 64'd0);
    chk("rst_rsp_id", 64'(o_rsp_id), 64'd0);
    chk("rst_rsp_product", o_rsp_product, 64'd0);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;

    // Single signed request from requester 2: -1 * 2
    grant_log.delete();
    enq(2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    wait_grant("t1", vec, t_acc);
    chk("t1_rdy", 64'(vec), 64'b0100);
    @(negedge i_clk);
    chk("t1_mult_vld", 64'(o_mult_vld), 64'd1);
    chk("t1_multa", 64'(o_multa), 64'hFFFF_FFFF);
    chk("t1_multb", 64'(o_multb), 64'd2);
    chk("t1_multa_ns", 64'(o_multa_ns), 64'd1);
    chk("t1_multb_ns", 64'(o_multb_ns), 64'd1);
    @(negedge i_clk);
    chk("t1_mult_vld_drop", 64'(o_mult_vld), 64'd0);
    chk("t1_multa_hold", 64'(o_multa), 64'hFFFF_FFFF);
    n = 0;
    while (!o_rsp_vld && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    lat = cyc - t_acc;
    chk("t1_latency", 64'(lat), 64'(MULT_LAT + 2));
    drain("t1");

    // Pointer at 3: requester 1 alone, then 0 and 1 together with pointer at 2
    enq(1, 32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 1'b1);
    wait_grant("t2a", vec, t_acc);
    chk("t2a_rdy", 64'(vec), 64'b0010);
    drain("t2a");
    enq(0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    enq(1, 32'h8000_0000, 32'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1);
    wait_grant("t2b", vec, t_acc);
    chk("t2b_rdy", 64'(vec), 64'b0001);
    drain("t2b");
    eg = '{2, 1, 0, 1, 0, 0, 0, 0};
    chk_log("t2_grants", 4, eg);

    // Unsigned path from requester 3 (pointer at 2)
    enq(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_grant("t3", vec, t_acc);
    chk("t3_rdy", 64'(vec), 64'b1000);
    @(negedge i_clk);
    chk("t3_multa_ns", 64'(o_multa_ns), 64'd0);
    chk("t3_multb_ns", 64'(o_multb_ns), 64'd0);
    drain("t3");

    // All requesters continuously valid, consumer always ready
    grant_log.delete();
    grant_cyc.delete();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        enq(k, 32'h100 * (k + 1) + r, 32'h10, 1'b0, 1'b0, 64'(32'h100 * (k + 1) + r) << 4, 1'b1);
      end
    end
    drain("t4");
    eg = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("t4_grants", 8, eg);
    if (grant_cyc.size() >= 4) begin
      chk("t4_back_to_back", 64'(grant_cyc[3] - grant_cyc[0]), 64'd3);
    end

    // Consumer stalled: exactly FIFO_DEPTH grants, then release
    @(posedge i_clk);
    #1 i_rsp_rdy = 1'b0;
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        enq(k, 32'h1000 * (k + 1) + r, 32'h100, 1'b0, 1'b0, 64'(32'h1000 * (k + 1) + r) << 8, 1'b1);
      end
    end
    repeat (15) @(negedge i_clk);
    chk("t5_stall_grants", 64'(grant_log.size()), 64'(FIFO_DEPTH));
    chk("t5_stall_rdy", 64'(o_req_rdy), 64'd0);
    chk("t5_stall_rsp_vld", 64'(o_rsp_vld), 64'd1);
    chk("t5_stall_head_id", 64'(o_rsp_id), 64'd0);
    @(posedge i_clk);
    #1 i_rsp_rdy = 1'b1;
    drain("t5");
    eg = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("t5_grants", 8, eg);

    // Reset with work in flight and queued; pointer left at 2 beforehand
    @(posedge i_clk);
    #1 i_rsp_rdy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      enq(1, 32'd100 + j, 32'd3, 1'b0, 1'b0, 64'd0, 1'b0);
    end
    repeat (6) @(negedge i_clk);
    @(posedge i_clk);
    #3;
    i_rstn = 1'b0;
    for (int k = 0; k < NREQ; k++) reqq[k].delete();
    exp_q.delete();
    @(negedge i_clk);
    chk("t6_rst_rsp_vld", 64'(o_rsp_vld), 64'd0);
    chk("t6_rst_mult_vld", 64'(o_mult_vld), 64'd0);
    repeat (2) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rstn    = 1'b1;
    i_rsp_rdy = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_rsp_vld) seen++;
    end
    chk("t6_no_stale_rsp", 64'(seen), 64'd0);
    grant_log.delete();
    enq(1, 32'd9, 32'd9, 1'b0, 1'b0, 64'd81, 1'b1);
    enq(3, 32'hFFFF_FFFE, 32'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1);
    drain("t6");
    eg = '{1, 3, 0, 0, 0, 0, 0, 0};
    chk_log("t6_grants", 2, eg);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin scheduler that shares one pipelined 32x32 signed/unsigned multiplier between NREQ requesters.
- Accepts requests over valid/ready, drives the multiplier operand and sign ports, and tracks in-flight requester IDs through a latency-matched tag pipeline.
- Returns each ID-tagged 64-bit product through a backpressurable response FIFO.
- Sits between the multiplier wrapper and the client blocks.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; equals clog2(NREQ).
- MULT_LAT, 2, cycles from operands presented on o_mult* to product valid on i_product.
- FIFO_DEPTH, 4, response FIFO entries (power of 2, >= MULT_LAT+1).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  async active-low reset.
- i_req_vld  in  NREQ  per-requester request valid.
- o_req_rdy  out  NREQ  per-requester accept, one-hot or zero.
- i_req_a_ns  in  NREQ  operand A sign mode per requester; 1 = signed.
- i_req_b_ns  in  NREQ  operand B sign mode per requester; 1 = signed.
- i_req_a  in  NREQ*32  operand A, requester k at bits [32k+31:32k].
- i_req_b  in  NREQ*32  operand B, same packing as i_req_a.
- o_mult_vld  out  1  operands on o_mult* are a real issue.
- o_multa_ns  out  1  to multiplier i_multa_ns.
- o_multb_ns  out  1  to multiplier i_multb_ns.
- o_multa  out  32  to multiplier i_multa.
- o_multb  out  32  to multiplier i_multb.
- i_product  in  64  from multiplier o_product.
- o_rsp_vld  out  1  response available.
- o_rsp_id  out  IDW  requester index of the response.
- o_rsp_product  out  64  product.
- i_rsp_rdy  in  1  response consumer accept.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rstn is asynchronous, active-low.
- Reset values: o_mult_vld=0, o_multa/o_multb/o_multa_ns/o_multb_ns=0, o_rsp_vld=0, o_rsp_id=0, o_rsp_product=0.
- Reset state: RR pointer=0, tag pipeline empty, FIFO empty, credit count=0.
- Credit: credits = in-flight tags + FIFO occupancy. A grant is allowed only when credits < FIFO_DEPTH. This guarantees no product is ever dropped.
- Arbitration: combinational round-robin.
  - Search starts at pointer p and wraps modulo NREQ.
  - The first k with i_req_vld[k]=1 gets o_req_rdy[k]=1, provided credit is available.
  - On a grant, p <= k+1 mod NREQ.
  - No grant leaves p unchanged.
- Requester rule: once i_req_vld is raised, it and the operands are held stable until the handshake. o_req_rdy never depends on i_req_rdy.
- Issue: on accept at edge t, o_mult_vld=1 and the registered operands and sign bits appear after t, for exactly one cycle.
- Idle issue: when no grant occurs, o_mult_vld=0 and the operand registers hold their previous values. This limits datapath toggle.
- Tag pipeline: a MULT_LAT-deep shift register of {vld,id}, loaded from the issue stage. When the tail is valid, i_product is written to the FIFO with that id.
- Throughput: one issue per cycle sustained while credits remain.
- FIFO:
  - o_rsp_vld = not empty.
  - Head is presented on o_rsp_id/o_rsp_product, registered.
  - Pop when o_rsp_vld && i_rsp_rdy.
  - Push and pop in the same cycle is legal, including when full or empty-with-bypass-disabled; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Credit update: grant increments, pop decrements, simultaneous grant+pop leaves credits unchanged.
- Minimum latency: accept edge t, response o_rsp_vld high after edge t+MULT_LAT+2.
- Ordering: responses leave in issue order, regardless of requester.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded; no spurious o_rsp_vld after reset release.
- Width/sign: sign handling belongs to the multiplier. The arbiter passes the ns bits through with their operands unchanged.

Decomposition:
- Shared package mult_pkg: MULT_W=32, PROD_W=64, and the operand-bundle typedef {ns_a, ns_b, a, b}.
- The response-tag typedef {id, product} also goes in mult_pkg.
- One sub-module, mult_rsp_fifo: a parameterised sync FIFO with registered head, full/empty, and occupancy output.
- The round-robin pick stays inline.

Test Plan:
- Single request, requester 2 with a=0xFFFFFFFF, b=2, both ns=1 → one issue with o_multa=0xFFFFFFFF, o_multa_ns=1; response id=2 with the model's product (-2 = 0xFFFFFFFFFFFFFFFE) at MULT_LAT+2 cycles.
- All 4 requesters valid continuously, i_rsp_rdy=1 → grants 0,1,2,3,0,... one per cycle; responses in the same id order with no bubbles.
- i_rsp_rdy=0 with all requesters valid → exactly FIFO_DEPTH grants, then o_req_rdy=0. Raise i_rsp_rdy → one new grant per pop, and no product is lost.
- Requester 1 alone, p=3 → grant 1; then requesters 0 and 1 both valid → requester 0 is skipped only if p has passed it; check p=2 grants 0 first after wrap.
- Unsigned path: a=0xFFFFFFFF, b=0xFFFFFFFF, ns=0 → product 0xFFFFFFFE00000001 with the correct id.
- Assert i_rstn low with 3 requests in flight and 2 queued → o_rsp_vld=0, o_mult_vld=0. After release, the first new request returns its correct id with no stale responses.
